roc_decoder: RTL and testbench

- Receiving end of the rank-order-coding (ROC) index stream: consumes pixel indices in descending-intensity order and reconstructs an approximate image.
- The k-th received index (0-based rank k) gets value PIXEL_MAX_VALUE - k*RANK_STEP, saturating at 0.
- Pixels never received read 0.
- Sits after the AER link / ROC encoder on the loopback, debug and reconstruction path; presents the reconstructed image for readback.

---
 rtl/roc_pkg.sv | 23 ++
 rtl/roc_rank_value.sv | 30 +++
 rtl/roc_decoder.sv | 147 ++++++++++++++
 tb/tb_roc_decoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/roc_pkg.sv
// Shared constants, pixel type and decoder state encoding for the ROC encoder/decoder pair.
package roc_pkg;

  localparam int IMAGE_SIZE_DEF      = 7;
  localparam int PIXEL_MAX_VALUE_DEF = 255;
  localparam int PIXEL_BITS_DEF      = $clog2(PIXEL_MAX_VALUE_DEF + 1);

  typedef logic [PIXEL_BITS_DEF-1:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_ACK     = 3'd3,
    ST_DONE    = 3'd4
  } roc_dec_state_t;

  // Index width for an image of n pixels, never narrower than one bit.
  function automatic int index_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/roc_rank_value.sv
// Rank to pixel value: PIXEL_MAX_VALUE - rank*RANK_STEP, saturating at zero.
module roc_rank_value
  import roc_pkg::*;
#(
  parameter int PIXEL_MAX_VALUE = PIXEL_MAX_VALUE_DEF,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1),
  parameter int INDEX_BITS      = index_bits(IMAGE_SIZE_DEF),
  parameter int RANK_STEP       = 1
) (
  input  logic [INDEX_BITS:0]   i_rank,
  output logic [PIXEL_BITS-1:0] o_value
);

  localparam int AW = PIXEL_BITS + INDEX_BITS + 1;
  localparam logic [AW-1:0] MAX_W  = AW'(PIXEL_MAX_VALUE);
  localparam logic [AW-1:0] STEP_W = AW'(RANK_STEP);

  logic [AW-1:0] w_product;

  // Widened product so large ranks clamp to zero instead of wrapping.
  always_comb begin
    w_product = AW'(i_rank) * STEP_W;
    if (w_product > MAX_W) begin
      o_value = '0;
    end else begin
      o_value = PIXEL_BITS'(MAX_W - w_product);
    end
  end

endmodule

// File: rtl/roc_decoder.sv
// ROC decoder: rebuilds an image from a rank-ordered pixel index stream over a 4-phase handshake.
module roc_decoder
  import roc_pkg::*;
#(
  parameter int IMAGE_SIZE      = IMAGE_SIZE_DEF,
  parameter int PIXEL_MAX_VALUE = PIXEL_MAX_VALUE_DEF,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1),
  parameter int INDEX_BITS      = index_bits(IMAGE_SIZE),
  parameter int RANK_STEP       = 1
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  START,
  input  logic                                  EVENT_VALID,
  input  logic [INDEX_BITS-1:0]                 EVENT_INDEX,
  input  logic                                  END_OF_STREAM,
  output logic                                  EVENT_BUSY,
  output logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
  output logic                                  IMAGE_VALID,
  output logic [INDEX_BITS:0]                   RANK_COUNT,
  output logic                                  INDEX_ERR,
  output logic                                  DUP_ERR
);

  localparam int CW = INDEX_BITS + 1;
  localparam logic [CW-1:0] SIZE_W   = CW'(IMAGE_SIZE);
  localparam logic [CW-1:0] RANK_ONE = CW'(1);

  roc_dec_state_t                        r_state;
  logic                                  r_busy;
  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] r_image;
  logic                                  r_valid;
  logic [CW-1:0]                         r_rank_count;
  logic                                  r_index_err;
  logic                                  r_dup_err;
  logic [IMAGE_SIZE-1:0]                 r_seen;

  logic [PIXEL_BITS-1:0] w_rank_value;
  logic                  w_index_ok;
  logic                  w_full;
  logic                  w_start_clear;

  roc_rank_value #(
    .PIXEL_MAX_VALUE (PIXEL_MAX_VALUE),
    .PIXEL_BITS      (PIXEL_BITS),
    .INDEX_BITS      (INDEX_BITS),
    .RANK_STEP       (RANK_STEP)
  ) u_rank_value (
    .i_rank  (r_rank_count),
    .o_value (w_rank_value)
  );

  assign w_index_ok = ({1'b0, EVENT_INDEX} < SIZE_W);
  assign w_full     = (r_rank_count == SIZE_W);
  // START only restarts from states where the handshake is not in flight.
  assign w_start_clear = START && ((r_state == ST_IDLE) || (r_state == ST_COLLECT) ||
                                   (r_state == ST_DONE));

  // Decoder FSM with registered handshake, image and status outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b1;
      r_image      <= '0;
      r_valid      <= 1'b0;
      r_rank_count <= '0;
      r_index_err  <= 1'b0;
      r_dup_err    <= 1'b0;
      r_seen       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_busy  <= 1'b1;
          r_state <= START ? ST_CLEAR : ST_IDLE;
        end
        ST_CLEAR: begin
          r_busy  <= 1'b0;
          r_state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (START) begin
            r_busy  <= 1'b1;
            r_state <= ST_CLEAR;
          end else if (w_full) begin
            // A full image can take no more ranks, so stop before any accept.
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else if (EVENT_VALID) begin
            r_busy  <= 1'b1;
            r_state <= ST_ACK;
            if (!w_index_ok) begin
              r_index_err <= 1'b1;
            end else if (r_seen[EVENT_INDEX]) begin
              r_dup_err <= 1'b1;
            end else begin
              r_image[EVENT_INDEX] <= w_rank_value;
              r_seen[EVENT_INDEX]  <= 1'b1;
              r_rank_count         <= r_rank_count + RANK_ONE;
            end
          end else if (END_OF_STREAM) begin
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_COLLECT;
          end
        end
        ST_ACK: begin
          if (EVENT_VALID) begin
            r_busy  <= 1'b1;
            r_state <= ST_ACK;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_COLLECT;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b1;
          r_state <= START ? ST_CLEAR : ST_DONE;
        end
        default: begin
          r_busy  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
      // Entering CLEAR wipes the frame so CLEAR itself already shows zeros.
      if (w_start_clear) begin
        r_image      <= '0;
        r_seen       <= '0;
        r_rank_count <= '0;
        r_index_err  <= 1'b0;
        r_dup_err    <= 1'b0;
        r_valid      <= 1'b0;
      end
    end
  end

  assign EVENT_BUSY  = r_busy;
  assign IMAGE       = r_image;
  assign IMAGE_VALID = r_valid;
  assign RANK_COUNT  = r_rank_count;
  assign INDEX_ERR   = r_index_err;
  assign DUP_ERR     = r_dup_err;

endmodule

// File: tb/tb_roc_decoder.sv
// Bench for roc_decoder: two instances (rank step 1 and 100) share one stimulus stream.
module tb_roc_decoder;
  import roc_pkg::*;

  localparam int N  = 7;
  localparam int PB = 8;
  localparam int IB = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          EVENT_VALID = 1'b0;
  logic          END_OF_STREAM = 1'b0;
  logic [IB-1:0] EVENT_INDEX = '0;

  logic                 busy1, busy2, valid1, valid2, ierr1, ierr2, derr1, derr2;
  logic [N-1:0][PB-1:0] img1, img2;
  logic [IB:0]          cnt1, cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  int m_img1 [N];
  int m_img2 [N];
  bit m_seen [N];
  int m_cnt;
  bit m_ierr, m_derr;

  roc_decoder #(.RANK_STEP(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START), .EVENT_VALID(EVENT_VALID),
    .EVENT_INDEX(EVENT_INDEX), .END_OF_STREAM(END_OF_STREAM), .EVENT_BUSY(busy1),
    .IMAGE(img1), .IMAGE_VALID(valid1), .RANK_COUNT(cnt1), .INDEX_ERR(ierr1), .DUP_ERR(derr1)
  );

  roc_decoder #(.RANK_STEP(100)) dut2 (
    .CLK(CLK), .RST(RST), .START(START), .EVENT_VALID(EVENT_VALID),
    .EVENT_INDEX(EVENT_INDEX), .END_OF_STREAM(END_OF_STREAM), .EVENT_BUSY(busy2),
    .IMAGE(img2), .IMAGE_VALID(valid2), .RANK_COUNT(cnt2), .INDEX_ERR(ierr2), .DUP_ERR(derr2)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_value(input int rank, input int step);
    int v;
    v = 255 - rank * step;
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_img1[i] = 0;
      m_img2[i] = 0;
      m_seen[i] = 1'b0;
    end
    m_cnt  = 0;
    m_ierr = 1'b0;
    m_derr = 1'b0;
  endtask

  task automatic model_accept(input int idx);
    if (idx >= N) begin
      m_ierr = 1'b1;
    end else if (m_seen[idx]) begin
      m_derr = 1'b1;
    end else begin
      m_img1[idx] = sat_value(m_cnt, 1);
      m_img2[idx] = sat_value(m_cnt, 100);
      m_seen[idx] = 1'b1;
      m_cnt++;
    end
  endtask

  task automatic check_all(input string tag, input bit eb, input bit ev);
    chk({tag, ".busy1"}, busy1, eb);
    chk({tag, ".busy2"}, busy2, eb);
    chk({tag, ".valid1"}, valid1, ev);
    chk({tag, ".valid2"}, valid2, ev);
    chk({tag, ".cnt1"}, cnt1, m_cnt);
    chk({tag, ".cnt2"}, cnt2, m_cnt);
    chk({tag, ".ierr1"}, ierr1, m_ierr);
    chk({tag, ".ierr2"}, ierr2, m_ierr);
    chk({tag, ".derr1"}, derr1, m_derr);
    chk({tag, ".derr2"}, derr2, m_derr);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.img1[%0d]", tag, i), img1[i], m_img1[i]);
      chk($sformatf("%s.img2[%0d]", tag, i), img2[i], m_img2[i]);
    end
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
    model_clear();
    check_all("clear", 1'b1, 1'b0);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (busy1 !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    chk("ready", busy1, 1'b0);
  endtask

  // Full 4-phase handshake; VALID is seen high on `hold` consecutive edges.
  task automatic send(input int idx, input int hold);
    wait_ready();
    EVENT_INDEX = IB'(idx);
    EVENT_VALID = 1'b1;
    tick();
    model_accept(idx);
    chk("busy_rise", busy1, 1'b1);
    chk("accept_cnt", cnt1, m_cnt);
    for (int c = 1; c < hold; c++) begin
      tick();
      chk("busy_hold", busy1, 1'b1);
      chk("hold_cnt", cnt1, m_cnt);
    end
    EVENT_VALID = 1'b0;
    tick();
    chk("busy_fall", busy1, 1'b0);
  endtask

  task automatic finish_eos();
    END_OF_STREAM = 1'b1;
    tick();
    END_OF_STREAM = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (valid1 !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
  endtask

  initial begin
    int order [7] = '{3, 0, 6, 1, 5, 2, 4};
    int exp_normal [7] = '{254, 252, 250, 255, 249, 251, 253};

    model_clear();
    repeat (3) tick();
    check_all("reset", 1'b1, 1'b0);
    RST = 1'b1;
    tick();
    check_all("idle", 1'b1, 1'b0);

    // Normal order
    do_start();
    foreach (order[i]) send(order[i], 1);
    wait_valid();
    check_all("normal", 1'b1, 1'b1);
    for (int i = 0; i < N; i++) chk($sformatf("normal_tbl[%0d]", i), img1[i], exp_normal[i]);

    // VALID in DONE is never accepted
    EVENT_INDEX = 3'd0;
    EVENT_VALID = 1'b1;
    repeat (3) tick();
    check_all("valid_in_done", 1'b1, 1'b1);
    EVENT_VALID = 1'b0;
    tick();

    // Early end
    do_start();
    send(2, 1);
    send(5, 1);
    finish_eos();
    check_all("early_end", 1'b1, 1'b1);
    chk("early_px5_step100", img2[5], 155);

    // Errors: duplicate and out-of-range
    do_start();
    send(4, 1);
    send(4, 1);
    chk("dup_err_set", derr1, 1'b1);
    chk("idx_err_clear", ierr1, 1'b0);
    send(7, 1);
    chk("idx_err_set", ierr1, 1'b1);
    chk("err_cnt", cnt1, 1);
    send(1, 1);
    finish_eos();
    check_all("errors", 1'b1, 1'b1);
    chk("errors_px4", img1[4], 255);
    chk("errors_px1", img1[1], 254);

    // Saturation on the step-100 instance
    do_start();
    for (int i = 0; i < 4; i++) send(i, 1);
    finish_eos();
    check_all("saturate", 1'b1, 1'b1);
    chk("sat_px0", img2[0], 255);
    chk("sat_px1", img2[1], 155);
    chk("sat_px2", img2[2], 55);
    chk("sat_px3", img2[3], 0);

    // Long hold and a START pulse dropped in ACK
    do_start();
    send(5, 5);
    check_all("long_hold", 1'b0, 1'b0);
    wait_ready();
    EVENT_INDEX = 3'd2;
    EVENT_VALID = 1'b1;
    tick();
    model_accept(2);
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    EVENT_VALID = 1'b0;
    tick();
    tick();
    check_all("start_in_ack", 1'b0, 1'b0);

    // Reset during ACK
    send(0, 1);
    EVENT_INDEX = 3'd6;
    EVENT_VALID = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    model_clear();
    check_all("rst_in_ack", 1'b1, 1'b0);
    RST = 1'b1;
    EVENT_VALID = 1'b0;
    tick();
    check_all("rst_release", 1'b1, 1'b0);

    // Restart from COLLECT discards partial data
    do_start();
    send(1, 1);
    send(3, 1);
    do_start();
    send(6, 1);
    chk("restart_px6", img1[6], 255);
    chk("restart_px1", img1[1], 0);
    finish_eos();
    check_all("restart", 1'b1, 1'b1);

    // Randomised frames against the model
    for (int r = 0; r < 20; r++) begin
      int n_ev;
      do_start();
      n_ev = $urandom_range(1, 10);
      for (int e = 0; e < n_ev && m_cnt < N; e++) begin
        send($urandom_range(0, 7), $urandom_range(1, 3));
      end
      if (m_cnt < N) finish_eos();
      else wait_valid();
      check_all($sformatf("rand%0d", r), 1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
